// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline control types: stage hold encoding and bus widths.
package hazard_ctrl_pkg;

  typedef logic [31:0] inst_addr_t;
  typedef logic [4:0]  reg_addr_t;

  typedef enum logic [2:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3
  } hold_e;

endpackage

// File: rtl/hazard_ctrl_perf.sv
// Saturating stall/flush cycle counters for hazard_ctrl.
// Instantiated only when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (i_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hold/flush sequencer: jump, interrupt, load-use, div and bus stalls.
// Optional perf counters when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LU_BUBBLES = 1,
  parameter int DIV_TMO    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       jump_flag_i,
  input  inst_addr_t jump_addr_i,
  input  logic       int_assert_i,
  input  inst_addr_t int_addr_i,
  input  logic       div_start_i,
  input  logic       div_busy_i,
  input  logic       bus_hold_i,
  input  reg_addr_t  id_reg1_raddr_i,
  input  reg_addr_t  id_reg2_raddr_i,
  input  logic       ex_load_i,
  input  reg_addr_t  ex_reg_waddr_i,
  output hold_e      hold_o,
  output logic       flush_o,
  output logic       jump_flag_o,
  output inst_addr_t jump_addr_o,
`ifdef HAZARD_CTRL_PERF_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic       div_tmo_o
);

  localparam int DCW = $clog2(DIV_TMO + 1);
  localparam logic [1:0] LU_LAST =
    2'((LU_BUBBLES > 1) ? (LU_BUBBLES - 2) : 0);
  localparam logic [DCW-1:0] TMO_LAST = DCW'(DIV_TMO - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_LU_STALL,
    S_DIV_WAIT,
    S_BUS_WAIT
  } state_e;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [1:0]     r_lu_cnt;
  logic [1:0]     w_lu_cnt_nxt;
  logic [DCW-1:0] r_div_cnt;
  logic [DCW-1:0] w_div_cnt_nxt;
  logic           w_lu_hit;

  assign w_lu_hit = ex_load_i && (ex_reg_waddr_i != '0) &&
                    ((ex_reg_waddr_i == id_reg1_raddr_i) ||
                     (ex_reg_waddr_i == id_reg2_raddr_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_lu_cnt  <= '0;
      r_div_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lu_cnt  <= w_lu_cnt_nxt;
      r_div_cnt <= w_div_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lu_cnt_nxt  = r_lu_cnt;
    w_div_cnt_nxt = r_div_cnt;
    hold_o        = HOLD_NONE;
    flush_o       = 1'b0;
    jump_flag_o   = 1'b0;
    jump_addr_o   = '0;
    div_tmo_o     = 1'b0;
    if (rst) begin
      w_state_nxt   = S_RUN;
      w_lu_cnt_nxt  = '0;
      w_div_cnt_nxt = '0;
    end else if (int_assert_i || jump_flag_i) begin
      jump_flag_o   = 1'b1;
      jump_addr_o   = int_assert_i ? int_addr_i : jump_addr_i;
      flush_o       = 1'b1;
      w_state_nxt   = S_RUN;
      w_lu_cnt_nxt  = '0;
      w_div_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        // bus wait with grant back behaves exactly like run
        S_RUN, S_BUS_WAIT: begin
          if (div_start_i) begin
            w_state_nxt   = S_DIV_WAIT;
            w_div_cnt_nxt = '0;
          end else if (bus_hold_i) begin
            hold_o      = HOLD_PC;
            w_state_nxt = S_BUS_WAIT;
          end else if (w_lu_hit) begin
            hold_o       = HOLD_ID;
            w_lu_cnt_nxt = '0;
            w_state_nxt  = (LU_BUBBLES > 1) ? S_LU_STALL : S_RUN;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        S_LU_STALL: begin
          hold_o = HOLD_ID;
          if (r_lu_cnt == LU_LAST) begin
            w_state_nxt  = S_RUN;
            w_lu_cnt_nxt = '0;
          end else begin
            w_lu_cnt_nxt = r_lu_cnt + 2'd1;
          end
        end
        S_DIV_WAIT: begin
          if (!div_busy_i) begin
            w_state_nxt   = S_RUN;
            w_div_cnt_nxt = '0;
          end else begin
            hold_o = HOLD_ID;
            if (r_div_cnt == TMO_LAST) begin
              div_tmo_o     = 1'b1;
              w_state_nxt   = S_RUN;
              w_div_cnt_nxt = '0;
            end else begin
              w_div_cnt_nxt = r_div_cnt + 1'b1;
            end
          end
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  hazard_ctrl_perf u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_stall     (hold_o != HOLD_NONE),
    .i_flush     (flush_o),
    .o_stall_cnt (stall_cnt_o),
    .o_flush_cnt (flush_cnt_o)
  );
`else
  // counters compiled out
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors, queued expectations.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int LU  = 2;
  localparam int TMO = 64;

  typedef struct {
    logic       rst;
    logic       jf;
    inst_addr_t ja;
    logic       ia;
    inst_addr_t iaddr;
    logic       ds;
    logic       db;
    logic       bh;
    reg_addr_t  r1;
    reg_addr_t  r2;
    logic       ld;
    reg_addr_t  wd;
  } in_t;

  typedef struct {
    string      name;
    hold_e      hold;
    logic       flush;
    logic       jf;
    inst_addr_t ja;
    logic       tmo;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       jump_flag_i;
  inst_addr_t jump_addr_i;
  logic       int_assert_i;
  inst_addr_t int_addr_i;
  logic       div_start_i;
  logic       div_busy_i;
  logic       bus_hold_i;
  reg_addr_t  id_reg1_raddr_i;
  reg_addr_t  id_reg2_raddr_i;
  logic       ex_load_i;
  reg_addr_t  ex_reg_waddr_i;
  hold_e      hold_o;
  logic       flush_o;
  logic       jump_flag_o;
  inst_addr_t jump_addr_o;
  logic       div_tmo_o;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LU_BUBBLES(LU), .DIV_TMO(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .int_assert_i    (int_assert_i),
    .int_addr_i      (int_addr_i),
    .div_start_i     (div_start_i),
    .div_busy_i      (div_busy_i),
    .bus_hold_i      (bus_hold_i),
    .id_reg1_raddr_i (id_reg1_raddr_i),
    .id_reg2_raddr_i (id_reg2_raddr_i),
    .ex_load_i       (ex_load_i),
    .ex_reg_waddr_i  (ex_reg_waddr_i),
    .hold_o          (hold_o),
    .flush_o         (flush_o),
    .jump_flag_o     (jump_flag_o),
    .jump_addr_o     (jump_addr_o),
`ifdef HAZARD_CTRL_PERF_EN
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o),
`endif
    .div_tmo_o       (div_tmo_o)
  );

  function automatic in_t idle();
    in_t v;
    v.rst = 1'b0; v.jf = 1'b0; v.ja = '0;
    v.ia = 1'b0; v.iaddr = '0; v.ds = 1'b0;
    v.db = 1'b0; v.bh = 1'b0; v.r1 = '0;
    v.r2 = '0; v.ld = 1'b0; v.wd = '0;
    return v;
  endfunction

  function automatic exp_t mk(string n, hold_e h, logic f,
                              logic j, inst_addr_t a, logic t);
    exp_t e;
    e.name = n; e.hold = h; e.flush = f;
    e.jf = j; e.ja = a; e.tmo = t;
    return e;
  endfunction

  function automatic exp_t quiet(string n, hold_e h);
    return mk(n, h, 1'b0, 1'b0, '0, 1'b0);
  endfunction

  task automatic cyc(input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    rst             = v.rst;
    jump_flag_i     = v.jf;
    jump_addr_i     = v.ja;
    int_assert_i    = v.ia;
    int_addr_i      = v.iaddr;
    div_start_i     = v.ds;
    div_busy_i      = v.db;
    bus_hold_i      = v.bh;
    id_reg1_raddr_i = v.r1;
    id_reg2_raddr_i = v.r2;
    ex_load_i       = v.ld;
    ex_reg_waddr_i  = v.wd;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (hold_o !== e.hold || flush_o !== e.flush ||
          jump_flag_o !== e.jf || jump_addr_o !== e.ja ||
          div_tmo_o !== e.tmo) begin
        n_fail++;
        $display("FAIL %s: got hold=%0d flush=%b jf=%b ja=%h tmo=%b, want hold=%0d flush=%b jf=%b ja=%h tmo=%b",
                 e.name, hold_o, flush_o, jump_flag_o, jump_addr_o,
                 div_tmo_o, e.hold, e.flush, e.jf, e.ja, e.tmo);
      end
    end
  end

  initial begin
    in_t v;
    rst = 1'b1;
    jump_flag_i = 1'b0; jump_addr_i = '0;
    int_assert_i = 1'b0; int_addr_i = '0;
    div_start_i = 1'b0; div_busy_i = 1'b0;
    bus_hold_i = 1'b0; id_reg1_raddr_i = '0;
    id_reg2_raddr_i = '0; ex_load_i = 1'b0;
    ex_reg_waddr_i = '0;

    v = idle(); v.rst = 1'b1;
    cyc(v, quiet("reset", HOLD_NONE));
    v.bh = 1'b1;
    cyc(v, quiet("reset_gated", HOLD_NONE));
    cyc(idle(), quiet("post_reset", HOLD_NONE));

    v = idle(); v.ld = 1'b1; v.wd = 5'd5; v.r1 = 5'd5;
    cyc(v, quiet("lu_rs1_first", HOLD_ID));
    for (int i = 1; i < LU; i++)
      cyc(idle(), quiet("lu_rs1_bubble", HOLD_ID));
    cyc(idle(), quiet("lu_rs1_done", HOLD_NONE));

    v = idle(); v.ld = 1'b1; v.wd = 5'd7; v.r2 = 5'd7; v.r1 = 5'd3;
    cyc(v, quiet("lu_rs2_first", HOLD_ID));
    for (int i = 1; i < LU; i++)
      cyc(idle(), quiet("lu_rs2_bubble", HOLD_ID));
    cyc(idle(), quiet("lu_rs2_done", HOLD_NONE));

    v = idle(); v.ld = 1'b1; v.wd = 5'd0; v.r1 = 5'd0;
    cyc(v, quiet("lu_x0", HOLD_NONE));
    cyc(idle(), quiet("lu_x0_after", HOLD_NONE));

    v = idle(); v.ld = 1'b1; v.wd = 5'd9; v.r1 = 5'd8;
    cyc(v, quiet("load_no_dep", HOLD_NONE));

    v = idle(); v.jf = 1'b1; v.ja = 32'h100;
    v.ld = 1'b1; v.wd = 5'd5; v.r1 = 5'd5;
    cyc(v, mk("jump_over_lu", HOLD_NONE, 1'b1, 1'b1, 32'h100, 1'b0));
    cyc(idle(), quiet("jump_no_bubble", HOLD_NONE));

    v = idle(); v.jf = 1'b1; v.ja = 32'h100;
    v.ia = 1'b1; v.iaddr = 32'h8;
    cyc(v, mk("int_over_jump", HOLD_NONE, 1'b1, 1'b1, 32'h8, 1'b0));
    cyc(idle(), quiet("int_after", HOLD_NONE));

    v = idle(); v.ds = 1'b1;
    cyc(v, quiet("div33_start", HOLD_NONE));
    v = idle(); v.db = 1'b1;
    for (int i = 0; i < 33; i++)
      cyc(v, quiet("div33_busy", HOLD_ID));
    cyc(idle(), quiet("div33_release", HOLD_NONE));
    cyc(idle(), quiet("div33_run", HOLD_NONE));

    v = idle(); v.ds = 1'b1;
    cyc(v, quiet("div64_start", HOLD_NONE));
    v = idle(); v.db = 1'b1;
    for (int i = 0; i < TMO - 1; i++)
      cyc(v, quiet("div64_busy", HOLD_ID));
    cyc(v, mk("div64_tmo", HOLD_ID, 1'b0, 1'b0, '0, 1'b1));
    cyc(v, quiet("div64_forced_run", HOLD_NONE));
    cyc(idle(), quiet("div64_idle", HOLD_NONE));

    v = idle(); v.bh = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc(v, quiet("bus_hold", HOLD_PC));
    cyc(idle(), quiet("bus_release", HOLD_NONE));

    v = idle(); v.ds = 1'b1; v.bh = 1'b1;
    cyc(v, quiet("div_over_bus", HOLD_NONE));
    v = idle(); v.db = 1'b1; v.bh = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(v, quiet("div_ignores_bus", HOLD_ID));
    cyc(idle(), quiet("div_bus_release", HOLD_NONE));

    v = idle(); v.ds = 1'b1;
    cyc(v, quiet("divj_start", HOLD_NONE));
    v = idle(); v.db = 1'b1;
    cyc(v, quiet("divj_busy", HOLD_ID));
    v.jf = 1'b1; v.ja = 32'h200;
    cyc(v, mk("divj_jump", HOLD_NONE, 1'b1, 1'b1, 32'h200, 1'b0));
    v = idle(); v.db = 1'b1;
    cyc(v, quiet("divj_run", HOLD_NONE));

    v = idle(); v.ds = 1'b1;
    cyc(v, quiet("divr_start", HOLD_NONE));
    v = idle(); v.db = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(v, quiet("divr_busy", HOLD_ID));
    v.rst = 1'b1;
    cyc(v, quiet("divr_reset", HOLD_NONE));
    v.rst = 1'b0;
    cyc(v, quiet("divr_run", HOLD_NONE));
    cyc(idle(), quiet("divr_idle", HOLD_NONE));

    v = idle(); v.ld = 1'b1; v.wd = 5'd4; v.r2 = 5'd4;
    cyc(v, quiet("lur_first", HOLD_ID));
    v = idle(); v.rst = 1'b1;
    cyc(v, quiet("lur_reset", HOLD_NONE));
    cyc(idle(), quiet("lur_no_bubble", HOLD_NONE));

    for (int i = 0; i < 10 && sb.size() != 0; i++)
      @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
